ram512_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of one RAM512 (512 x 16, synchronous write, combinational read).
- Lets two requesters (port 0: CPU side, port 1: DMA/loader side) share the single RAM through a req/ack handshake with round-robin fairness.
- Drives the RAM's load/address/in pins and captures its out bus.
- Sits beside RAM512 in the memory subsystem.

---
 rtl/ram512_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ram512_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ram512_arbiter.sv
// ----------------------------------------------------------------------------
// ram512_arbiter
//
// Two-port round-robin arbiter and access sequencer in front of a single
// RAM512 (512 x 16, synchronous write, combinational read). Each access runs
// IDLE -> ACCESS -> RESP, one cycle per state. The ack for an access is a
// single-cycle pulse in RESP. A request that is still high after its ack is
// served again as a new request.
//
// Optional feature (macro RAM512_ARB_CLEAR_EN):
//   After reset release the FSM sweeps the whole RAM with zeros, writing one
//   word per cycle, before init_done rises. Requests are ignored during the
//   sweep. If the macro is undefined, init_done rises on the first clock edge
//   after rst_n is released.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/1, we0/1           request and write-enable per port (held until ack)
//   addr0/1, wdata0/1       word address and write data per port
//   ack0, ack1              one-cycle completion pulse per port
//   rdata                   read data, or the written data for a write;
//                           valid during an ack and held otherwise
//   ram_load, ram_address,  RAM512 control and data in
//   ram_in
//   ram_out                 RAM512 data out
//   init_done               arbiter is accepting requests
// ----------------------------------------------------------------------------
module ram512_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          ram_load,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_in,
  input  logic [DW-1:0] ram_out,
  output logic          init_done
);

`ifdef RAM512_ARB_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
`endif

  state_t state_r;
  logic   pri1_r;     // 1: port 1 wins the next contention
  logic   gnt_id_r;   // port owning the access in flight
`ifdef RAM512_ARB_CLEAR_EN
  logic [AW-1:0] clr_cnt_r;
`endif

  logic grant_valid_s;
  logic grant_id_s;

  // Arbitration: a lone requester wins; on contention the preferred port wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0 && req1) begin
      grant_valid_s = 1'b1;
      grant_id_s    = pri1_r;
    end else if (req0) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // Sequencer FSM. The ram_* registers also act as the latched request:
  // ram_load holds we, ram_address holds addr and ram_in holds wdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM512_ARB_CLEAR_EN
      state_r     <= ST_CLEAR;
      clr_cnt_r   <= {AW{1'b0}};
`else
      state_r     <= ST_IDLE;
`endif
      pri1_r      <= 1'b0;
      gnt_id_r    <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata       <= {DW{1'b0}};
      ram_load    <= 1'b0;
      ram_address <= {AW{1'b0}};
      ram_in      <= {DW{1'b0}};
      init_done   <= 1'b0;
    end else begin
`ifdef RAM512_ARB_CLEAR_EN
      init_done <= init_done;
`else
      init_done <= 1'b1;
`endif
      case (state_r)
        ST_IDLE: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          ram_load <= 1'b0;
          if (init_done && grant_valid_s) begin
            gnt_id_r    <= grant_id_s;
            pri1_r      <= ~grant_id_s;
            ram_address <= grant_id_s ? addr1  : addr0;
            ram_in      <= grant_id_s ? wdata1 : wdata0;
            ram_load    <= grant_id_s ? we1    : we0;
            state_r     <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // For a write, the RAM takes ram_in on this edge. Echo the written
          // data so rdata does not depend on RAM write-through timing.
          rdata    <= ram_load ? ram_in : ram_out;
          ram_load <= 1'b0;
          ack0     <= ~gnt_id_r;
          ack1     <= gnt_id_r;
          state_r  <= ST_RESP;
        end
        ST_RESP: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          ram_load <= 1'b0;
          state_r  <= ST_IDLE;
        end
`ifdef RAM512_ARB_CLEAR_EN
        ST_CLEAR: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          // ram_load is low only in the first sweep cycle, before word 0 is
          // presented. Once the last word is being written, finish.
          if (ram_load && (ram_address == {AW{1'b1}})) begin
            ram_load  <= 1'b0;
            init_done <= 1'b1;
            clr_cnt_r <= {AW{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            ram_load    <= 1'b1;
            ram_address <= clr_cnt_r;
            ram_in      <= {DW{1'b0}};
            clr_cnt_r   <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
            state_r     <= ST_CLEAR;
          end
        end
`endif
        default: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          ram_load <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram512_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram512_arbiter
//
// Directed self-checking bench for ram512_arbiter in the default build.
// A behavioural RAM512 model sits on the ram_* pins. Inputs are driven on
// the falling edge, and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ram512_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [8:0]  addr0 = 9'd0, addr1 = 9'd0;
  logic [15:0] wdata0 = 16'd0, wdata1 = 16'd0;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        ram_load;
  logic [8:0]  ram_address;
  logic [15:0] ram_in;
  logic [15:0] ram_out;
  logic        init_done;

  int n_vec = 0;
  int n_err = 0;
  int both_ack_cnt = 0;

  logic [15:0] mem [0:511];

  ram512_arbiter #(.AW(9), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
    .ram_out(ram_out), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // RAM512 model: synchronous write, combinational read
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  // ack0 and ack1 must never be high together
  always @(negedge clk) if (ack0 && ack1) both_ack_cnt <= both_ack_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse reset and check reset values and init_done timing. Ends on a
  // falling edge in IDLE with init_done = 1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_acks"}, {ack0, ack1}, 2'b00);
    chk({tag, "_rst_rdata"}, rdata, 16'h0000);
    chk({tag, "_rst_load"}, ram_load, 1'b0);
    chk({tag, "_rst_addr"}, ram_address, 9'h000);
    chk({tag, "_rst_in"}, ram_in, 16'h0000);
    chk({tag, "_rst_init"}, init_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk({tag, "_init_before_edge"}, init_done, 1'b0);
    @(negedge clk);
    chk({tag, "_init_after_edge"}, init_done, 1'b1);
  endtask

  // Run one isolated access. Call on a falling edge while the DUT is in IDLE.
  task automatic do_req(input int port, input logic we, input logic [8:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
    end
    @(negedge clk);  // ACCESS
    chk({tag, "_acc_acks"}, {ack0, ack1}, 2'b00);
    chk({tag, "_acc_load"}, ram_load, we);
    chk({tag, "_acc_addr"}, ram_address, a);
    @(negedge clk);  // RESP
    chk({tag, "_resp_acks"}, {ack0, ack1}, (port == 0) ? 2'b10 : 2'b01);
    chk({tag, "_resp_rdata"}, rdata, exp_rd);
    chk({tag, "_resp_load"}, ram_load, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);  // back in IDLE
    chk({tag, "_idle_acks"}, {ack0, ack1}, 2'b00);
    chk({tag, "_idle_hold"}, rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [8:0] a;

    // Reset, then port 0 write/read with ack at +2
    do_reset("r0");
    do_req(0, 1'b1, 9'h1A5, 16'hBEEF, 16'hBEEF, "p0_wr");
    do_req(0, 1'b0, 9'h1A5, 16'h0000, 16'hBEEF, "p0_rd");

    // Preload for the contention test, then reset so port 0 is favoured
    do_req(0, 1'b1, 9'h010, 16'h1111, 16'h1111, "pre0");
    do_req(1, 1'b1, 9'h020, 16'h2222, 16'h2222, "pre1");
    do_reset("r1");

    // Contention: both ports read continuously, so grants alternate 0,1,0,1
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h020;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      chk("cont_acc_addr", ram_address, (g % 2 == 0) ? 9'h010 : 9'h020);
      chk("cont_acc_acks", {ack0, ack1}, 2'b00);
      @(negedge clk);
      chk("cont_resp_acks", {ack0, ack1}, (g % 2 == 0) ? 2'b10 : 2'b01);
      chk("cont_rdata", rdata, (g % 2 == 0) ? 16'h1111 : 16'h2222);
      if (g == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
      chk("cont_idle_acks", {ack0, ack1}, 2'b00);
    end

    // Streaming: port 1 writes i to 0x1F8+i with req held throughout
    req1 = 1'b1; we1 = 1'b1; addr1 = 9'h1F8; wdata1 = 16'd0;
    for (int i = 0; i < 8; i++) begin
      a = 9'h1F8 + 9'(i);
      @(negedge clk);
      chk("strm_acc_load", ram_load, 1'b1);
      chk("strm_acc_addr", ram_address, a);
      chk("strm_acc_acks", {ack0, ack1}, 2'b00);
      @(negedge clk);
      chk("strm_resp_acks", {ack0, ack1}, 2'b01);
      chk("strm_resp_rdata", rdata, 16'(i));
      chk("strm_resp_load", ram_load, 1'b0);
      if (i < 7) begin
        addr1 = a + 9'd1;
        wdata1 = 16'(i + 1);
      end else begin
        req1 = 1'b0;
      end
      @(negedge clk);
      chk("strm_idle_load", ram_load, 1'b0);
      chk("strm_idle_acks", {ack0, ack1}, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      do_req(1, 1'b0, 9'h1F8 + 9'(i), 16'h0000, 16'(i), "strm_rb");
    end

    // Reset during ACCESS of a port-0 read. The held request completes after release.
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    @(negedge clk);
    chk("mid_acc_addr", ram_address, 9'h010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acks", {ack0, ack1}, 2'b00);
    chk("mid_rst_addr", ram_address, 9'h000);
    chk("mid_rst_rdata", rdata, 16'h0000);
    chk("mid_rst_init", init_done, 1'b0);
    @(negedge clk);
    chk("mid_rst_noack", {ack0, ack1}, 2'b00);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack0 && lat == 0) lat = k;
    end
    chk("mid_ack_latency", lat, 3);
    chk("mid_rdata", rdata, 16'h1111);
    req0 = 1'b0;
    @(negedge clk);

    chk("ack_exclusive", both_ack_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
